// File: rtl/uart_rx_fifo_core_if.sv
// Bus bundle for uart_rx_fifo_core.
// Groups the register access port and the received-frame stream port.
//   master : register initiator and frame consumer (drives valid/wr/address/data, frame_ready)
//   slave  : the receiver core (drives ack/data_out*, frame/flags/frame_valid/fifo_count)
interface uart_rx_fifo_core_if #(
  parameter int DATA_MAX   = 9,
  parameter int FIFO_DEPTH = 8
) ();
  logic                          valid;
  logic                          wr;
  logic [3:0]                    address;
  logic [3:0]                    data;
  logic                          ack;
  logic                          data_out_valid;
  logic [3:0]                    data_out;
  logic [DATA_MAX-1:0]           frame;
  logic                          parity_err;
  logic                          framing_err;
  logic                          frame_valid;
  logic                          frame_ready;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (
    output valid, wr, address, data, frame_ready,
    input  ack, data_out_valid, data_out, frame, parity_err, framing_err,
           frame_valid, fifo_count
  );

  modport slave (
    input  valid, wr, address, data, frame_ready,
    output ack, data_out_valid, data_out, frame, parity_err, framing_err,
           frame_valid, fifo_count
  );
endinterface

// File: rtl/uart_rx_fifo_core.sv
// UART receiver with register file, programmable 16x oversample divisor and
// a first-word-fall-through receive FIFO, all on a single clock.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   Rx   : asynchronous serial input, idles high
//   bus  : register access (valid/wr/address/data -> ack/data_out_valid/data_out)
//          and frame stream (frame/parity_err/framing_err/frame_valid/fifo_count,
//          popped by frame_ready)
//
// state  | meaning
// IDLE   | waiting for falling edge on synchronised Rx, config shadows track live regs
// START  | confirm start bit at half-bit
// DATA   | sample frame_length data bits, LSB first
// PARITY | sample parity bit
// STOP   | sample one or two stop bits, push on the last one
module uart_rx_fifo_core #(
  parameter int DATA_MAX    = 9,
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 27
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Rx,
  uart_rx_fifo_core_if.slave bus
);
  localparam int         PW          = $clog2(FIFO_DEPTH);
  localparam int         CW          = PW + 1;
  localparam int         NIB         = DIV_W / 4;
  localparam int         EW          = DATA_MAX + 2;
  localparam logic [3:0] STATUS_ADDR = 4'(2 + NIB);
  localparam logic [3:0] LEN_MIN     = 4'd5;
  localparam logic [3:0] LEN_MAX     = 4'(DATA_MAX);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic             parity_en, parity_type, stop_bits;
  logic [3:0]       frame_length;
  logic [DIV_W-1:0] divisor;
  logic             overflow;
  logic [CW-1:0]    count;
  logic             rx_busy, fifo_full, not_empty;
  logic [3:0]       rdata;
  logic             reg_wr, reg_rd, div_wr, status_rd;
  state_t           state;

  // ---------------- register file ----------------
  assign reg_wr    = bus.valid & bus.wr;
  assign reg_rd    = bus.valid & ~bus.wr;
  assign status_rd = reg_rd && (bus.address == STATUS_ADDR);
  assign div_wr    = reg_wr && (bus.address >= 4'd2) && (bus.address < STATUS_ADDR);

  always_comb begin
    rdata = 4'd0;
    if (bus.address == 4'd0) rdata = {1'b0, stop_bits, parity_type, parity_en};
    else if (bus.address == 4'd1) rdata = frame_length;
    else if (bus.address == STATUS_ADDR) rdata = {1'b0, fifo_full, rx_busy, overflow};
    else begin
      for (int k = 0; k < NIB; k++)
        if (bus.address == 4'(k + 2)) rdata = divisor[4*k +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ack            <= 1'b0;
      bus.data_out_valid <= 1'b0;
      bus.data_out       <= 4'd0;
      parity_en          <= 1'b0;
      parity_type        <= 1'b0;
      stop_bits          <= 1'b0;
      frame_length       <= 4'd8;
      divisor            <= DIV_W'(DEFAULT_DIV);
    end else begin
      bus.ack            <= bus.valid;
      bus.data_out_valid <= reg_rd;
      bus.data_out       <= reg_rd ? rdata : 4'd0;
      if (reg_wr) begin
        if (bus.address == 4'd0) {stop_bits, parity_type, parity_en} <= bus.data[2:0];
        // short lengths are stored as the minimum so the readback shows the value in use
        if (bus.address == 4'd1) frame_length <= (bus.data < LEN_MIN) ? LEN_MIN : bus.data;
        for (int k = 0; k < NIB; k++)
          if (bus.address == 4'(k + 2)) divisor[4*k +: 4] <= bus.data;
      end
    end
  end

  // ---------------- synchroniser and oversample tick ----------------
  logic             rx_s1, rx_s2, rx_prev;
  logic [DIV_W-1:0] baud_cnt, sh_div, div_eff;
  logic             tick, start_det;

  assign div_eff   = (sh_div == '0) ? DIV_W'(1) : sh_div;
  // >= keeps the counter bounded if the divisor shrinks under it
  assign tick      = baud_cnt >= (div_eff - DIV_W'(1));
  assign start_det = (state == IDLE) && rx_prev && !rx_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      baud_cnt <= '0;
    end else begin
      rx_s1   <= Rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (div_wr || start_det || tick) baud_cnt <= '0;
      else baud_cnt <= baud_cnt + DIV_W'(1);
    end
  end

  // ---------------- receive FSM ----------------
  logic [3:0]          sub_cnt, bit_idx, sh_len;
  logic [DATA_MAX-1:0] shift_q;
  logic                par_acc, perr, ferr, stop2_pending;
  logic                sh_par_en, sh_par_type, sh_stop2;
  logic                push;
  logic [EW-1:0]       push_entry;
  logic                mid;

  assign mid     = tick && (sub_cnt == 4'd15);
  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sub_cnt       <= 4'd0;
      bit_idx       <= 4'd0;
      shift_q       <= '0;
      par_acc       <= 1'b0;
      perr          <= 1'b0;
      ferr          <= 1'b0;
      stop2_pending <= 1'b0;
      sh_par_en     <= 1'b0;
      sh_par_type   <= 1'b0;
      sh_stop2      <= 1'b0;
      sh_len        <= 4'd8;
      sh_div        <= DIV_W'(DEFAULT_DIV);
      push          <= 1'b0;
      push_entry    <= '0;
    end else begin
      push <= 1'b0;
      if (tick && state != IDLE) sub_cnt <= sub_cnt + 4'd1;
      case (state)
        IDLE: begin
          // shadows follow the live config so they hold it frozen once a frame starts
          sh_par_en   <= parity_en;
          sh_par_type <= parity_type;
          sh_stop2    <= stop_bits;
          sh_len      <= (frame_length > LEN_MAX) ? LEN_MAX : frame_length;
          sh_div      <= divisor;
          if (start_det) begin
            state   <= START;
            sub_cnt <= 4'd0;
            bit_idx <= 4'd0;
            shift_q <= '0;
            par_acc <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
          end
        end
        START: begin
          if (tick && sub_cnt == 4'd7) begin
            sub_cnt <= 4'd0;
            state   <= rx_s2 ? IDLE : DATA;
          end
        end
        DATA: begin
          if (mid) begin
            sub_cnt          <= 4'd0;
            shift_q[bit_idx] <= rx_s2;
            par_acc          <= par_acc ^ rx_s2;
            bit_idx          <= bit_idx + 4'd1;
            stop2_pending    <= sh_stop2;
            if (bit_idx == sh_len - 4'd1) state <= sh_par_en ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (mid) begin
            sub_cnt <= 4'd0;
            perr    <= (par_acc ^ rx_s2) != sh_par_type;
            state   <= STOP;
          end
        end
        STOP: begin
          if (mid) begin
            sub_cnt <= 4'd0;
            if (!rx_s2) ferr <= 1'b1;
            if (stop2_pending) stop2_pending <= 1'b0;
            else begin
              push       <= 1'b1;
              push_entry <= {ferr | ~rx_s2, perr, shift_q};
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------- receive FIFO ----------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          pop, wr_en;

  assign not_empty = (count != '0);
  assign fifo_full = (count == CW'(FIFO_DEPTH));
  assign pop       = not_empty && bus.frame_ready;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign wr_en     = push && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (wr_en && !pop) count <= count + CW'(1);
      else if (pop && !wr_en) count <= count - CW'(1);
      if (push && fifo_full && !pop) overflow <= 1'b1;
      else if (status_rd) overflow <= 1'b0;
    end
  end

  assign bus.frame_valid = not_empty;
  assign bus.fifo_count  = count;
  assign {bus.framing_err, bus.parity_err, bus.frame} = not_empty ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_uart_rx_fifo_core.sv
// Self-checking bench for uart_rx_fifo_core: register vector table, directed
// frame sequences and randomized frames against a queue-based frame model.
module tb_uart_rx_fifo_core;
  localparam int DATA_MAX    = 9;
  localparam int FIFO_DEPTH  = 8;
  localparam int DIV_W       = 16;
  localparam int DEFAULT_DIV = 27;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  uart_rx_fifo_core_if #(.DATA_MAX(DATA_MAX), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  uart_rx_fifo_core #(
    .DATA_MAX(DATA_MAX), .FIFO_DEPTH(FIFO_DEPTH),
    .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk(clk), .rst(rst), .Rx(rx), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] payload;
    logic       perr;
    logic       ferr;
  } frm_t;

  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [3:0] wdata;
    logic [3:0] exp;
  } vec_t;

  frm_t exp_q[$];
  logic m_ovf = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [3:0] q, qe;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic reg_access(input logic w, input logic [3:0] a, input logic [3:0] d,
                            output logic [3:0] rd);
    @(negedge clk);
    bus.valid = 1'b1; bus.wr = w; bus.address = a; bus.data = d;
    @(negedge clk);
    bus.valid = 1'b0; bus.wr = 1'b0;
    chk("ack", bus.ack, 1);
    chk("data_out_valid", bus.data_out_valid, 32'(!w));
    rd = bus.data_out;
    @(negedge clk);
    chk("ack_low", bus.ack, 0);
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [3:0] d);
    logic [3:0] dummy;
    reg_access(1'b1, a, d, dummy);
  endtask

  // model: the FIFO as a bounded queue with a sticky drop flag
  function automatic void expect_frame(input logic [8:0] p, input int len, input bit pen,
                                       input bit pbit, input bit ptype, input int nstop,
                                       input bit [1:0] stopv);
    frm_t e;
    logic [8:0] m;
    m = p & 9'((1 << len) - 1);
    e.payload = m;
    e.perr = pen ? (((^m) ^ pbit) != ptype) : 1'b0;
    e.ferr = (nstop == 2) ? !(stopv[0] && stopv[1]) : !stopv[0];
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(e);
    else m_ovf = 1'b1;
  endfunction

  task automatic tx(input logic [8:0] p, input int len, input bit pen, input bit pbit,
                    input bit ptype, input int nstop, input bit [1:0] stopv, input int bclk);
    logic [15:0] v;
    int n;
    expect_frame(p, len, pen, pbit, ptype, nstop, stopv);
    v = '1; v[0] = 1'b0; n = 1;
    for (int i = 0; i < len; i++) begin v[n] = p[i]; n++; end
    if (pen) begin v[n] = pbit; n++; end
    v[n] = stopv[0]; n++;
    if (nstop == 2) begin v[n] = stopv[1]; n++; end
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      rx = v[i];
      repeat (bclk) @(negedge clk);
    end
    rx = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic pop_check(input string tag);
    frm_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk({tag, "_empty"}, bus.frame_valid, 0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_valid"}, bus.frame_valid, 1);
    chk({tag, "_frame"}, bus.frame, e.payload);
    chk({tag, "_perr"}, bus.parity_err, e.perr);
    chk({tag, "_ferr"}, bus.framing_err, e.ferr);
    bus.frame_ready = 1'b1;
    @(negedge clk);
    bus.frame_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ack"}, bus.ack, 0);
    chk({tag, "_dov"}, bus.data_out_valid, 0);
    chk({tag, "_dout"}, bus.data_out, 0);
    chk({tag, "_fvalid"}, bus.frame_valid, 0);
    chk({tag, "_frame"}, bus.frame, 0);
    chk({tag, "_perr"}, bus.parity_err, 0);
    chk({tag, "_ferr"}, bus.framing_err, 0);
    chk({tag, "_count"}, bus.fifo_count, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [20];
    logic [8:0] pl;
    int cfg, lenw, len;
    bit [1:0] sv;

    vt[0]  = '{1'b0, 4'd0,  4'd0, 4'h0};
    vt[1]  = '{1'b0, 4'd1,  4'd0, 4'h8};
    vt[2]  = '{1'b0, 4'd2,  4'd0, 4'hB};
    vt[3]  = '{1'b0, 4'd3,  4'd0, 4'h1};
    vt[4]  = '{1'b0, 4'd4,  4'd0, 4'h0};
    vt[5]  = '{1'b0, 4'd5,  4'd0, 4'h0};
    vt[6]  = '{1'b0, 4'd6,  4'd0, 4'h0};
    vt[7]  = '{1'b0, 4'd15, 4'd0, 4'h0};
    vt[8]  = '{1'b1, 4'd1,  4'd9, 4'h0};
    vt[9]  = '{1'b0, 4'd1,  4'd0, 4'h9};
    vt[10] = '{1'b1, 4'd1,  4'd2, 4'h0};
    vt[11] = '{1'b0, 4'd1,  4'd0, 4'h5};
    vt[12] = '{1'b1, 4'd0,  4'hF, 4'h0};
    vt[13] = '{1'b0, 4'd0,  4'd0, 4'h7};
    vt[14] = '{1'b1, 4'd6,  4'hF, 4'h0};
    vt[15] = '{1'b0, 4'd6,  4'd0, 4'h0};
    vt[16] = '{1'b1, 4'd15, 4'hF, 4'h0};
    vt[17] = '{1'b0, 4'd15, 4'd0, 4'h0};
    vt[18] = '{1'b1, 4'd0,  4'd0, 4'h0};
    vt[19] = '{1'b1, 4'd1,  4'd8, 4'h0};

    bus.valid = 1'b0; bus.wr = 1'b0; bus.address = 4'd0; bus.data = 4'd0;
    bus.frame_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    for (int i = 0; i < 20; i++) begin
      reg_access(vt[i].wr, vt[i].addr, vt[i].wdata, q);
      if (!vt[i].wr) chk($sformatf("reg_vec%0d", i), q, vt[i].exp);
    end

    // divisor = 4 -> 64 clk per bit
    reg_write(4'd2, 4'd4);
    reg_write(4'd3, 4'd0);

    // 8N1 0xA5
    tx(9'h0A5, 8, 0, 0, 0, 1, 2'b11, 64);
    chk("a_count", bus.fifo_count, 1);
    pop_check("a");
    chk("a_empty_valid", bus.frame_valid, 0);
    chk("a_empty_frame", bus.frame, 0);

    // odd parity, 7 bits
    reg_write(4'd0, 4'd3);
    reg_write(4'd1, 4'd7);
    tx(9'h041, 7, 1, 1, 1, 1, 2'b11, 64);
    tx(9'h041, 7, 1, 0, 1, 1, 2'b11, 64);
    chk("b_count", bus.fifo_count, 2);
    pop_check("b1");
    pop_check("b2");

    // two stop bits, second low
    reg_write(4'd0, 4'd4);
    reg_write(4'd1, 4'd8);
    tx(9'h03C, 8, 0, 0, 0, 2, 2'b01, 64);
    chk("c_count", bus.fifo_count, 1);
    pop_check("c");
    // 2-clk glitch: false start
    @(negedge clk); rx = 1'b0;
    repeat (2) @(negedge clk); rx = 1'b1;
    repeat (8) @(negedge clk);
    reg_access(1'b0, 4'd6, 4'd0, q);
    chk("glitch_busy", q, 2);
    repeat (80) @(negedge clk);
    chk("glitch_count", bus.fifo_count, 0);
    reg_access(1'b0, 4'd6, 4'd0, q);
    chk("glitch_status", q, 0);

    // overflow: FIFO_DEPTH+2 frames with no consumer
    reg_write(4'd0, 4'd0);
    for (int f = 0; f < FIFO_DEPTH + 2; f++) begin
      pl = 9'($urandom_range(0, 255));
      tx(pl, 8, 0, 0, 0, 1, 2'b11, 64);
    end
    chk("d_count", bus.fifo_count, 8);
    reg_access(1'b0, 4'd6, 4'd0, q);
    chk("d_status1", q, {1'b0, exp_q.size() == FIFO_DEPTH, 1'b0, m_ovf});
    chk("d_status1_const", q, 5);
    m_ovf = 1'b0;
    reg_access(1'b0, 4'd6, 4'd0, q);
    chk("d_status2", q, 4);
    for (int f = 0; f < FIFO_DEPTH; f++) pop_check($sformatf("d%0d", f));
    chk("d_drained", bus.fifo_count, 0);

    // randomized frames and config against the model
    for (int f = 0; f < 14; f++) begin
      cfg  = $urandom_range(0, 7);
      lenw = $urandom_range(3, 15);
      reg_write(4'd0, 4'(cfg));
      reg_write(4'd1, 4'(lenw));
      len = (lenw < 5) ? 5 : ((lenw > DATA_MAX) ? DATA_MAX : lenw);
      pl  = 9'($urandom);
      sv  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      tx(pl, len, cfg[0], 1'($urandom), cfg[1], cfg[2] ? 2 : 1, sv, 64);
      chk($sformatf("rnd_count%0d", f), bus.fifo_count, exp_q.size());
      if ($urandom_range(0, 1) == 1) pop_check($sformatf("rnd_pop%0d", f));
    end
    reg_access(1'b0, 4'd6, 4'd0, q);
    chk("rnd_status", q, {1'b0, exp_q.size() == FIFO_DEPTH, 1'b0, m_ovf});
    m_ovf = 1'b0;
    while (exp_q.size() > 0) pop_check("rnd_drain");
    chk("rnd_drained", bus.fifo_count, 0);

    // divisor write mid-frame
    reg_write(4'd0, 4'd0);
    reg_write(4'd1, 4'd8);
    fork
      tx(9'h03C, 8, 0, 0, 0, 1, 2'b11, 64);
      begin
        repeat (150) @(negedge clk);
        reg_access(1'b0, 4'd6, 4'd0, qe);
        chk("e_busy", qe, 2);
        reg_access(1'b1, 4'd2, 4'd8, qe);
      end
    join
    pop_check("e1");
    reg_access(1'b0, 4'd2, 4'd0, q);
    chk("e_div", q, 8);
    tx(9'h0C3, 8, 0, 0, 0, 1, 2'b11, 128);
    pop_check("e2");

    // reset during DATA
    tx(9'h011, 8, 0, 0, 0, 1, 2'b11, 128);
    chk("f_pre_count", bus.fifo_count, 1);
    reg_write(4'd0, 4'd5);
    reg_write(4'd1, 4'd6);
    @(negedge clk); rx = 1'b0;
    repeat (128) @(negedge clk); rx = 1'b1;
    repeat (128) @(negedge clk); rx = 1'b0;
    repeat (64) @(negedge clk);
    reg_access(1'b0, 4'd6, 4'd0, q);
    chk("f_busy", q, 2);
    rx = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("f_reset");
    rst = 1'b0;
    exp_q.delete();
    m_ovf = 1'b0;
    reg_access(1'b0, 4'd0, 4'd0, q); chk("f_cfg", q, 0);
    reg_access(1'b0, 4'd1, 4'd0, q); chk("f_len", q, 8);
    reg_access(1'b0, 4'd2, 4'd0, q); chk("f_div0", q, 4'hB);
    reg_access(1'b0, 4'd3, 4'd0, q); chk("f_div1", q, 4'h1);
    reg_access(1'b0, 4'd6, 4'd0, q); chk("f_status", q, 0);
    tx(9'h05A, 8, 0, 0, 0, 1, 2'b11, 16 * DEFAULT_DIV);
    chk("f_count", bus.fifo_count, 1);
    pop_check("f");
    chk("f_final_count", bus.fifo_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo_core.md
Name: uart_rx_fifo_core

Overview:
Parametrised successor to the UART receive subsystem. It merges the serial receiver, its configuration register file and a new receive FIFO into one single-clock block. The 16x oversample tick comes from a programmable divisor rather than a separate baud clock. Received frames carry per-frame parity and framing error flags, are buffered in a first-word-fall-through FIFO, and are drained with a valid/ready handshake by the VGA-side consumer.

Parameters:
DATA_MAX, 9, widest frame payload in bits (frame_length is clamped to 5..DATA_MAX).
FIFO_DEPTH, 8, receive FIFO entries (power of two, >=2).
DIV_W, 16, baud divisor width (must be a multiple of 4).
DEFAULT_DIV, 27, divisor reset value; oversample tick rate = clk/divisor.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  synchronous, active-high reset.
Rx  in  1  serial input; asynchronous, idles high.
valid  in  1  register access strobe; one access per asserted cycle.
wr  in  1  1 = write, 0 = read; sampled with valid.
address  in  4  register address.
data  in  4  write data nibble.
ack  out  1  one-cycle pulse, 1 clk after every access.
data_out_valid  out  1  one-cycle pulse with ack, reads only.
data_out  out  4  read data; meaningful only while data_out_valid is high.
frame  out  DATA_MAX  FIFO head payload, right-justified, zero-extended.
parity_err  out  1  parity error flag of the FIFO head.
framing_err  out  1  framing (stop bit) error flag of the FIFO head.
frame_valid  out  1  FIFO not empty.
frame_ready  in  1  consumer pop; a pop occurs when frame_valid & frame_ready.
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values:
  - ack=0, data_out_valid=0, data_out=0, frame_valid=0, frame=0, parity_err=0, framing_err=0, fifo_count=0.
  - FIFO pointers 0, overflow=0, FSM=IDLE, Rx synchroniser flops=1.
  - cfg: parity_en=0, parity_type=0, stop_bits=0, frame_length=8, divisor=DEFAULT_DIV.
- Register map (address, write/read):
  - 0: cfg. bit0 parity_en, bit1 parity_type (0 even, 1 odd), bit2 stop_bits (0 one, 1 two).
  - 1: frame_length. Values <5 read back and act as 5; values >DATA_MAX act as DATA_MAX.
  - 2..(1+DIV_W/4): divisor nibbles, LSB first.
  - Next address: status, read-only. bit0 overflow, bit1 rx_busy, bit2 fifo_full. A read returns the value, then clears overflow.
  - Other addresses: writes ignored, reads return 0, ack still pulses.
- Access timing: access sampled in cycle N; ack (and data_out_valid for reads) pulse high in cycle N+1. Back-to-back accesses are legal.
- Baud tick:
  - Counter runs 0..divisor-1 and emits a one-cycle tick at divisor-1.
  - Divisor 0 is treated as 1 (tick every clk).
  - Counter restarts from 0 on a divisor write.
- Rx passes through a 2-flop synchroniser before any use.
- Config shadowing: cfg, frame_length and divisor are latched into shadow registers on leaving IDLE. Writes during a frame take effect on the next frame.
- FSM (one bit = 16 ticks):
  - IDLE: a falling edge on the synchronised Rx moves to START and zeroes the tick counter.
  - START: sample at tick 8. Low moves to DATA. High is a false start and returns to IDLE, with no push.
  - DATA: sample at mid-bit, LSB first, frame_length bits. Next state is PARITY if parity_en, else STOP.
  - PARITY: mid-bit sample. parity_err = (XOR of data bits ^ parity bit) != parity_type.
  - STOP: sample 1 or 2 stop bits at mid-bit. Any low sample sets framing_err. After the last stop sample, push and return to IDLE; do not wait for the end of the bit.
- rx_busy = FSM != IDLE.
- FIFO:
  - Entry = {framing_err, parity_err, payload}.
  - First-word-fall-through: frame, parity_err and framing_err show the head combinationally from storage. frame, parity_err and framing_err are 0 while empty.
  - A push when full and no pop in the same cycle drops the new frame and sets sticky overflow.
  - A simultaneous push and pop when full is accepted; count is unchanged.
  - A pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame aborts reception: no partial push, FIFO emptied, config restored to reset values.

Test Plan:
- Divisor=4 (64 clk/bit), 8N1, Rx sends 0xA5 -> after the stop bit, frame_valid=1, frame=0x0A5, parity_err=0, framing_err=0, fifo_count=1; one cycle with frame_ready=1 -> frame_valid=0.
- cfg=0x3 (odd parity), frame_length=7, send 0x41 with parity bit 1 -> parity_err=0; repeat with parity bit 0 -> parity_err=1; both entries queued in order.
- cfg stop_bits=1, second stop bit driven low -> framing_err=1, frame still pushed; a 2-clk low glitch on idle Rx -> no push (false start).
- frame_ready=0, send FIFO_DEPTH+2 frames -> fifo_count=8, frames 9..10 dropped, status read = 0x5, next status read = 0x4; drained order matches frames 1..8.
- Register access: write addr1=9, then read addr1 -> ack and data_out_valid one cycle after each access, data_out=9; read addr 15 -> data_out=0, ack=1; write divisor mid-frame -> current frame unaffected, next frame uses the new rate.
- Assert rst during the DATA state -> next cycle all outputs at reset values, fifo_count=0; a following frame at DEFAULT_DIV is received correctly.
